// File: rtl/read_operand_pkg.sv
// Shared definitions for the read-operand stage: PRF address width, PC width
// and the operand source select encoding used by each lane's operand muxes.
package read_operand_pkg;

  localparam int NCPU_PRF_AW     = 6;
  localparam int PC_W            = 32;
  localparam int NCPU_RO_OPSEL_W = 2;

  typedef enum logic [NCPU_RO_OPSEL_W-1:0] {
    OPSEL_ZERO = 2'd0,
    OPSEL_PRF  = 2'd1,
    OPSEL_HOLD = 2'd2,
    OPSEL_BYP  = 2'd3
  } opsel_t;

  // A disabled source always reads as zero; a bypass hit beats the hold copy.
  function automatic opsel_t opsel_pick(input logic re, input logic hold, input logic byp_hit);
    if (!re)     return OPSEL_ZERO;
    if (byp_hit) return OPSEL_BYP;
    if (hold)    return OPSEL_HOLD;
    return OPSEL_PRF;
  endfunction

endpackage

// File: rtl/read_operand_lane.sv
// One read-operand lane: s1 and hold registers, operand muxes and, when
// NCPU_RO_BYPASS_EN is defined, writeback bypass comparators.
module read_operand_lane
  import read_operand_pkg::*;
#(
  parameter int DW    = 32,
  parameter int UOP_W = 16,
  parameter int WW    = 2,
  parameter int AW    = NCPU_PRF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ro_valid,
  output logic              ro_ready,
  input  logic [UOP_W-1:0]  ro_uop,
  input  logic [AW-1:0]     prs1,
  input  logic [AW-1:0]     prs2,
  input  logic              prs1_re,
  input  logic              prs2_re,
  output logic [1:0]        prf_re,
  output logic [2*AW-1:0]   prf_raddr,
  input  logic [2*DW-1:0]   prf_rdata,
  input  logic [WW-1:0]     wb_we,
  input  logic [WW*AW-1:0]  wb_prd,
  input  logic [WW*DW-1:0]  wb_dat,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [UOP_W-1:0]  ex_uop,
  output logic [DW-1:0]     op1,
  output logic [DW-1:0]     op2
);

  logic             s1_valid;
  logic             hold;
  logic [UOP_W-1:0] s1_uop;
  logic [AW-1:0]    s1_prs1;
  logic [AW-1:0]    s1_prs2;
  logic             s1_re1;
  logic             s1_re2;
  logic [DW-1:0]    hold_op1;
  logic [DW-1:0]    hold_op2;
  logic             accept;
  logic             hit1;
  logic             hit2;
  logic [DW-1:0]    byp1;
  logic [DW-1:0]    byp2;
  opsel_t           sel1;
  opsel_t           sel2;

  // Flush gating is folded in here too so the lane never accepts in a flush cycle.
  assign ro_ready  = ~rst & (~s1_valid | ex_ready);
  assign accept    = ro_valid & ro_ready & ~flush;
  assign prf_re    = {prs2_re & accept, prs1_re & accept};
  assign prf_raddr = {prs2, prs1};

  assign ex_valid  = s1_valid;
  assign ex_uop    = s1_uop;

`ifdef NCPU_RO_BYPASS_EN
  // Later ports overwrite earlier matches, so the highest-index port wins.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    byp1 = '0;
    byp2 = '0;
    for (int w = 0; w < WW; w++) begin
      if (s1_valid && wb_we[w] && (wb_prd[w*AW +: AW] == s1_prs1)) begin
        hit1 = 1'b1;
        byp1 = wb_dat[w*DW +: DW];
      end
      if (s1_valid && wb_we[w] && (wb_prd[w*AW +: AW] == s1_prs2)) begin
        hit2 = 1'b1;
        byp2 = wb_dat[w*DW +: DW];
      end
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_prd, wb_dat, s1_prs1, s1_prs2};
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign byp1 = '0;
  assign byp2 = '0;
`endif

  assign sel1 = opsel_pick(s1_re1, hold, hit1);
  assign sel2 = opsel_pick(s1_re2, hold, hit2);

  always_comb begin
    op1 = '0;
    case (sel1)
      OPSEL_PRF:  op1 = prf_rdata[DW-1:0];
      OPSEL_HOLD: op1 = hold_op1;
      OPSEL_BYP:  op1 = byp1;
      default:    op1 = '0;
    endcase
  end

  always_comb begin
    op2 = '0;
    case (sel2)
      OPSEL_PRF:  op2 = prf_rdata[2*DW-1:DW];
      OPSEL_HOLD: op2 = hold_op2;
      OPSEL_BYP:  op2 = byp2;
      default:    op2 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      hold     <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      hold     <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      hold     <= 1'b0;
    end else if (s1_valid) begin
      if (ex_ready) begin
        s1_valid <= 1'b0;
        hold     <= 1'b0;
      end else begin
        hold     <= 1'b1;
      end
    end
  end

  // The PRF read data is only valid for one cycle, so a stalled uop keeps its own copy.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_uop  <= ro_uop;
      s1_prs1 <= prs1;
      s1_prs2 <= prs2;
      s1_re1  <= prs1_re;
      s1_re2  <= prs2_re;
    end
    if (s1_valid && !ex_ready) begin
      hold_op1 <= op1;
      hold_op2 <= op2;
    end
  end

endmodule

// File: rtl/read_operand.sv
// Read-operand stage top: IW independent lanes between the reservation
// stations and EX. Optional writeback bypass is enabled by NCPU_RO_BYPASS_EN.
module read_operand
  import read_operand_pkg::*;
#(
  parameter int CONFIG_DW            = 32,
  parameter int CONFIG_P_ISSUE_WIDTH = 1,
  parameter int CONFIG_P_WB_WIDTH    = 1,
  parameter int CONFIG_UOP_W         = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                flush,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                ro_valid,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                ro_ready,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_UOP_W-1:0]   ro_uop,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)*NCPU_PRF_AW-1:0]    ro_prs1,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)*NCPU_PRF_AW-1:0]    ro_prs2,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                ro_prs1_re,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                ro_prs2_re,
  output logic [2*(1<<CONFIG_P_ISSUE_WIDTH)-1:0]              prf_re,
  output logic [2*(1<<CONFIG_P_ISSUE_WIDTH)*NCPU_PRF_AW-1:0]  prf_raddr,
  input  logic [2*(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_DW-1:0]    prf_rdata,
  input  logic [(1<<CONFIG_P_WB_WIDTH)-1:0]                   wb_we,
  input  logic [(1<<CONFIG_P_WB_WIDTH)*NCPU_PRF_AW-1:0]       wb_prd,
  input  logic [(1<<CONFIG_P_WB_WIDTH)*CONFIG_DW-1:0]         wb_dat,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                ex_valid,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                ex_ready,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_UOP_W-1:0]   ex_uop,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_DW-1:0]      ex_op1,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_DW-1:0]      ex_op2
);

  localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int WW = 1 << CONFIG_P_WB_WIDTH;
  localparam int DW = CONFIG_DW;
  localparam int AW = NCPU_PRF_AW;
  localparam int UW = CONFIG_UOP_W;

  logic [IW-1:0] lane_ready;

  assign ro_ready = lane_ready & {IW{~flush}};

  for (genvar i = 0; i < IW; i++) begin : g_lane
    read_operand_lane #(
      .DW    (DW),
      .UOP_W (UW),
      .WW    (WW),
      .AW    (AW)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .ro_valid  (ro_valid[i]),
      .ro_ready  (lane_ready[i]),
      .ro_uop    (ro_uop[i*UW +: UW]),
      .prs1      (ro_prs1[i*AW +: AW]),
      .prs2      (ro_prs2[i*AW +: AW]),
      .prs1_re   (ro_prs1_re[i]),
      .prs2_re   (ro_prs2_re[i]),
      .prf_re    (prf_re[2*i +: 2]),
      .prf_raddr (prf_raddr[2*i*AW +: 2*AW]),
      .prf_rdata (prf_rdata[2*i*DW +: 2*DW]),
      .wb_we     (wb_we),
      .wb_prd    (wb_prd),
      .wb_dat    (wb_dat),
      .ex_valid  (ex_valid[i]),
      .ex_ready  (ex_ready[i]),
      .ex_uop    (ex_uop[i*UW +: UW]),
      .op1       (ex_op1[i*DW +: DW]),
      .op2       (ex_op2[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_read_operand.sv
// Bench for read_operand: PRF model with one-cycle read data, a per-lane
// scoreboard of expected {uop, op1, op2}, and one task per scenario.
module tb_read_operand;
  localparam int IW = 2;
  localparam int WW = 2;
  localparam int DW = 32;
  localparam int UW = 16;
  localparam int AW = read_operand_pkg::NCPU_PRF_AW;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [IW-1:0]       ro_valid;
  logic [IW-1:0]       ro_ready;
  logic [IW*UW-1:0]    ro_uop;
  logic [IW*AW-1:0]    ro_prs1;
  logic [IW*AW-1:0]    ro_prs2;
  logic [IW-1:0]       ro_prs1_re;
  logic [IW-1:0]       ro_prs2_re;
  logic [2*IW-1:0]     prf_re;
  logic [2*IW*AW-1:0]  prf_raddr;
  logic [2*IW*DW-1:0]  prf_rdata;
  logic [WW-1:0]       wb_we;
  logic [WW*AW-1:0]    wb_prd;
  logic [WW*DW-1:0]    wb_dat;
  logic [IW-1:0]       ex_valid;
  logic [IW-1:0]       ex_ready;
  logic [IW*UW-1:0]    ex_uop;
  logic [IW*DW-1:0]    ex_op1;
  logic [IW*DW-1:0]    ex_op2;

  int n_cmp = 0;
  int n_bad = 0;

  read_operand #(
    .CONFIG_DW(DW), .CONFIG_P_ISSUE_WIDTH(1), .CONFIG_P_WB_WIDTH(1), .CONFIG_UOP_W(UW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ro_valid(ro_valid), .ro_ready(ro_ready), .ro_uop(ro_uop),
    .ro_prs1(ro_prs1), .ro_prs2(ro_prs2), .ro_prs1_re(ro_prs1_re), .ro_prs2_re(ro_prs2_re),
    .prf_re(prf_re), .prf_raddr(prf_raddr), .prf_rdata(prf_rdata),
    .wb_we(wb_we), .wb_prd(wb_prd), .wb_dat(wb_dat),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_uop(ex_uop),
    .ex_op1(ex_op1), .ex_op2(ex_op2)
  );

  always #5 clk = ~clk;

  // PRF model: data is only meaningful the cycle after a read enable.
  logic [DW-1:0] prf_mem [64];
  logic [DW-1:0] prf_rd  [2*IW];

  always @(posedge clk) begin
    for (int k = 0; k < 2*IW; k++)
      prf_rd[k] <= prf_re[k] ? prf_mem[prf_raddr[k*AW +: AW]] : 32'hDEAD_DEAD;
  end
  assign prf_rdata = {prf_rd[3], prf_rd[2], prf_rd[1], prf_rd[0]};

  typedef struct packed {
    logic [UW-1:0] uop;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          re1;
    logic          re2;
    logic [AW-1:0] prs1;
    logic [AW-1:0] prs2;
  } exp_t;

  exp_t sb [IW][$];
  exp_t e;

  always @(negedge clk) begin
    if (!rst) begin
      for (int l = 0; l < IW; l++) begin
        if (ex_valid[l]) begin
          if (sb[l].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_spurious lane %0d: ex_valid=1 uop=%h, expected no valid uop", l, ex_uop[l*UW +: UW]);
          end else begin
            e = sb[l][0];
`ifdef NCPU_RO_BYPASS_EN
            for (int w = 0; w < WW; w++) begin
              if (wb_we[w] && e.re1 && wb_prd[w*AW +: AW] == e.prs1) e.op1 = wb_dat[w*DW +: DW];
              if (wb_we[w] && e.re2 && wb_prd[w*AW +: AW] == e.prs2) e.op2 = wb_dat[w*DW +: DW];
            end
`endif
            sb[l][0] = e;
            if (ex_ready[l]) begin
              n_cmp++;
              if ({ex_uop[l*UW +: UW], ex_op1[l*DW +: DW], ex_op2[l*DW +: DW]} !== {e.uop, e.op1, e.op2}) begin
                n_bad++;
                $display("FAIL sb_transfer lane %0d: got uop=%h op1=%h op2=%h, expected uop=%h op1=%h op2=%h",
                         l, ex_uop[l*UW +: UW], ex_op1[l*DW +: DW], ex_op2[l*DW +: DW], e.uop, e.op1, e.op2);
              end
              void'(sb[l].pop_front());
            end
          end
        end
        if (flush) sb[l].delete();
        if (ro_valid[l] && ro_ready[l]) begin
          e.uop  = ro_uop[l*UW +: UW];
          e.prs1 = ro_prs1[l*AW +: AW];
          e.prs2 = ro_prs2[l*AW +: AW];
          e.re1  = ro_prs1_re[l];
          e.re2  = ro_prs2_re[l];
          e.op1  = e.re1 ? prf_mem[e.prs1] : '0;
          e.op2  = e.re2 ? prf_mem[e.prs2] : '0;
          sb[l].push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int l, input logic [UW-1:0] uop, input logic [AW-1:0] p1,
                       input logic [AW-1:0] p2, input logic r1, input logic r2);
    ro_uop[l*UW +: UW]  = uop;
    ro_prs1[l*AW +: AW] = p1;
    ro_prs2[l*AW +: AW] = p2;
    ro_prs1_re[l]       = r1;
    ro_prs2_re[l]       = r2;
  endtask

  task automatic test_reset();
    rst = 1'b1; ro_valid = '1; ro_prs1_re = '1; ro_prs2_re = '1; ex_ready = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (ex_valid !== 2'b00) begin n_bad++; $display("FAIL reset_ex_valid: got %b, expected 00", ex_valid); end
      n_cmp++; if (ro_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ro_ready: got %b, expected 00", ro_ready); end
      n_cmp++; if (prf_re !== 4'b0000) begin n_bad++; $display("FAIL reset_prf_re: got %b, expected 0000", prf_re); end
      step();
    end
    rst = 1'b0; ro_valid = '0; ro_prs1_re = '0; ro_prs2_re = '0;
    step();
  endtask

  task automatic test_simple_read();
    prf_mem[5] = 32'h1234; prf_mem[7] = 32'h99;
    ex_ready = 2'b11;
    drive(0, 16'h0011, 6'd5, 6'd7, 1'b1, 1'b1);
    ro_valid = 2'b01;
    @(negedge clk);
    n_cmp++; if (prf_re[1:0] !== 2'b11) begin n_bad++; $display("FAIL simple_prf_re: got %b, expected 11", prf_re[1:0]); end
    n_cmp++; if (prf_raddr[2*AW-1:0] !== {6'd7, 6'd5}) begin n_bad++; $display("FAIL simple_raddr: got %h, expected %h", prf_raddr[2*AW-1:0], {6'd7, 6'd5}); end
    step();
    ro_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (ex_valid[0] !== 1'b1 || ex_op1[DW-1:0] !== 32'h1234 || ex_op2[DW-1:0] !== 32'h99) begin
      n_bad++; $display("FAIL simple_ex: got v=%b op1=%h op2=%h, expected v=1 op1=1234 op2=99", ex_valid[0], ex_op1[DW-1:0], ex_op2[DW-1:0]);
    end
    step();
    @(negedge clk);
    n_cmp++; if (ex_valid[0] !== 1'b0) begin n_bad++; $display("FAIL simple_idle: got ex_valid=%b, expected 0", ex_valid[0]); end
    step();
  endtask

  task automatic test_stall_hold();
    ex_ready = 2'b10;
    drive(0, 16'h0022, 6'd5, 6'd7, 1'b1, 1'b1);
    ro_valid = 2'b01;
    step();
    prf_mem[5] = 32'h0;
    drive(0, 16'h0023, 6'd9, 6'd10, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (ex_valid[0] !== 1'b1 || ro_ready[0] !== 1'b0 || prf_re[1:0] !== 2'b00) begin
        n_bad++; $display("FAIL stall_ctrl cyc %0d: got v=%b rdy=%b re=%b, expected v=1 rdy=0 re=00", c, ex_valid[0], ro_ready[0], prf_re[1:0]);
      end
      n_cmp++; if (ex_op1[DW-1:0] !== 32'h1234) begin n_bad++; $display("FAIL stall_op1 cyc %0d: got %h, expected 1234", c, ex_op1[DW-1:0]); end
      step();
    end
    ex_ready = 2'b11;
    @(negedge clk);
    n_cmp++; if (ex_uop[UW-1:0] !== 16'h0022 || ro_ready[0] !== 1'b1) begin
      n_bad++; $display("FAIL stall_release: got uop=%h rdy=%b, expected uop=0022 rdy=1", ex_uop[UW-1:0], ro_ready[0]);
    end
    step();
    ro_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (ex_valid[0] !== 1'b1 || ex_uop[UW-1:0] !== 16'h0023) begin
      n_bad++; $display("FAIL stall_next: got v=%b uop=%h, expected v=1 uop=0023", ex_valid[0], ex_uop[UW-1:0]);
    end
    step();
    prf_mem[5] = 32'h1234;
  endtask

  task automatic test_back_to_back();
    ex_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        drive(1, 16'h0040 + 16'(k), 6'(10 + k), 6'(20 + k), 1'b1, 1'b1);
        ro_valid = 2'b10;
      end else begin
        ro_valid = 2'b00;
      end
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        n_cmp++; if (ex_valid[1] !== 1'b1 || ex_uop[2*UW-1:UW] !== 16'h0040 + 16'(k - 1)) begin
          n_bad++; $display("FAIL b2b cyc %0d: got v=%b uop=%h, expected v=1 uop=%h", k, ex_valid[1], ex_uop[2*UW-1:UW], 16'h0040 + 16'(k - 1));
        end
      end else if (k == 5) begin
        n_cmp++; if (ex_valid[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got ex_valid=%b, expected 0", ex_valid[1]); end
      end
      step();
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
`ifdef NCPU_RO_BYPASS_EN
    exp1 = 32'h5555; exp2 = 32'h7777;
`else
    exp1 = 32'h1234; exp2 = 32'h99;
`endif
    ex_ready = 2'b11;
    drive(0, 16'h0050, 6'd5, 6'd7, 1'b1, 1'b1);
    ro_valid = 2'b01;
    step();
    ro_valid = 2'b00;
    wb_we = 2'b11; wb_prd = {6'd5, 6'd5}; wb_dat = {32'h5555, 32'hABCD};
    @(negedge clk);
    n_cmp++; if (ex_op1[DW-1:0] !== exp1) begin n_bad++; $display("FAIL bypass_op1: got %h, expected %h", ex_op1[DW-1:0], exp1); end
    step();
    wb_we = 2'b00;
    ex_ready = 2'b10;
    drive(0, 16'h0051, 6'd5, 6'd7, 1'b1, 1'b1);
    ro_valid = 2'b01;
    step();
    ro_valid = 2'b00;
    wb_we = 2'b01; wb_prd = {6'd0, 6'd7}; wb_dat = {32'h0, 32'h7777};
    step();
    wb_we = 2'b00; ex_ready = 2'b11;
    @(negedge clk);
    n_cmp++; if (ex_op2[DW-1:0] !== exp2) begin n_bad++; $display("FAIL bypass_hold_op2: got %h, expected %h", ex_op2[DW-1:0], exp2); end
    step();
  endtask

  task automatic test_flush_re0();
    ex_ready = 2'b10;
    drive(0, 16'h0060, 6'd3, 6'd4, 1'b1, 1'b1);
    ro_valid = 2'b01;
    step();
    @(negedge clk);
    n_cmp++; if (ex_valid[0] !== 1'b1) begin n_bad++; $display("FAIL flush_pre: got ex_valid=%b, expected 1", ex_valid[0]); end
    step();
    flush = 1'b1;
    drive(0, 16'h0061, 6'd3, 6'd4, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (ro_ready !== 2'b00 || prf_re !== 4'b0000) begin
      n_bad++; $display("FAIL flush_cycle: got rdy=%b re=%b, expected rdy=00 re=0000", ro_ready, prf_re);
    end
    step();
    flush = 1'b0; ro_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (ex_valid !== 2'b00) begin n_bad++; $display("FAIL flush_after: got ex_valid=%b, expected 00", ex_valid); end
    step();
    ex_ready = 2'b11;
    drive(0, 16'h0070, 6'd5, 6'd7, 1'b0, 1'b1);
    ro_valid = 2'b01;
    @(negedge clk);
    n_cmp++; if (prf_re[1:0] !== 2'b10) begin n_bad++; $display("FAIL re0_prf_re: got %b, expected 10", prf_re[1:0]); end
    step();
    ro_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (ex_op1[DW-1:0] !== 32'h0 || ex_op2[DW-1:0] !== 32'h99) begin
      n_bad++; $display("FAIL re0_ops: got op1=%h op2=%h, expected op1=0 op2=99", ex_op1[DW-1:0], ex_op2[DW-1:0]);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prf_mem[i] = 32'h1000 + 32'(i * 37);
    rst = 1'b1; flush = 1'b0; ro_valid = '0; ro_uop = '0; ro_prs1 = '0; ro_prs2 = '0;
    ro_prs1_re = '0; ro_prs2_re = '0; wb_we = '0; wb_prd = '0; wb_dat = '0; ex_ready = '0;
    test_reset();
    test_simple_read();
    test_stall_hold();
    test_back_to_back();
    test_bypass();
    test_flush_re0();
    step(); step();
    n_cmp++;
    if (sb[0].size() != 0 || sb[1].size() != 0) begin
      n_bad++; $display("FAIL sb_leftover: got %0d/%0d pending, expected 0/0", sb[0].size(), sb[1].size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
